// File: rtl/sram_responder.sv
// Purpose: SLC3 external-SRAM responder backed by an on-chip word array, with a side-band preload port.
// Latency: writes commit on the sampling edge; read data is driven READ_LATENCY edges after the request edge.
// Backpressure: none; the bus is released combinationally on CE_N=1, OE_N=1 or WE_N=0, and a bus access blocks preload.
module sram_responder #(
    parameter int ADDR_BITS    = 10,
    parameter int READ_LATENCY = 1
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [19:0]          A,
    input  logic                 CE_N,
    input  logic                 OE_N,
    input  logic                 WE_N,
    input  logic                 UB_N,
    input  logic                 LB_N,
    inout  wire  [15:0]          Mem_bus,
    input  logic                 Load_en,
    input  logic [ADDR_BITS-1:0] Load_addr,
    input  logic [15:0]          Load_data,
    output logic                 Data_valid,
    output logic                 Range_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRIVE = 2'd2
    } state_t;

    // Counter value loaded on a new request; WAIT steps down to zero, then DRIVE.
    localparam logic [1:0] LAT_LOAD = 2'(READ_LATENCY - 1);

    logic [15:0]          mem_q [2**ADDR_BITS];

    state_t               state_q, state_d;
    logic [1:0]           cnt_q, cnt_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic                 range_err_q, range_err_d;

    logic                 wr_acc;
    logic                 rd_acc;
    logic                 in_range;
    logic [15:0]          rd_word;

    // Write wins over read; a read needs WE_N high.
    assign wr_acc   = !CE_N && !WE_N;
    assign rd_acc   = !CE_N && !OE_N && WE_N;
    assign in_range = (A[19:ADDR_BITS] == '0);

    // Read FSM next state: any write, a dropped read or an out-of-range read returns to IDLE;
    // a new request or an address change (re)starts the latency count.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        range_err_d = (wr_acc || rd_acc) && !in_range;
        if (wr_acc || !rd_acc || !in_range) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else if (state_q == S_IDLE || A[ADDR_BITS-1:0] != addr_q) begin
            state_d = S_WAIT;
            cnt_d   = LAT_LOAD;
            addr_d  = A[ADDR_BITS-1:0];
        end else if (state_q == S_WAIT) begin
            if (cnt_q == '0) begin
                state_d = S_DRIVE;
            end else begin
                cnt_d = cnt_q - 2'd1;
            end
        end
    end

    // FSM and status registers; the array itself is deliberately left out of reset.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            range_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            range_err_q <= range_err_d;
        end
    end

    // Array update: byte-masked bus writes, or a full-word preload only while the bus is deselected.
    always_ff @(posedge Clk) begin
        if (wr_acc && in_range) begin
            if (!UB_N) begin
                mem_q[A[ADDR_BITS-1:0]][15:8] <= Mem_bus[15:8];
            end
            if (!LB_N) begin
                mem_q[A[ADDR_BITS-1:0]][7:0] <= Mem_bus[7:0];
            end
        end else if (Load_en && CE_N) begin
            mem_q[Load_addr] <= Load_data;
        end
    end

    // The word is re-read every cycle so a preload to the latched address shows up immediately.
    assign rd_word    = mem_q[addr_q];

    // Gated by the live strobes so the bus turns around without waiting for a clock edge.
    assign Data_valid = (state_q == S_DRIVE) && rd_acc;
    assign Range_err  = range_err_q;

    assign Mem_bus[15:8] = (Data_valid && !UB_N) ? rd_word[15:8] : 8'hzz;
    assign Mem_bus[7:0]  = (Data_valid && !LB_N) ? rd_word[7:0]  : 8'hzz;

endmodule

// File: tb/tb_sram_responder.sv
// Purpose: directed checks of sram_responder at READ_LATENCY 1 and 3 side by side.
// Latency: inputs change and outputs are sampled 1 ns after each rising edge.
// Backpressure: not applicable; the bench owns every strobe.
module tb_sram_responder;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [19:0] A;
    logic        CE_N, OE_N, WE_N, UB_N, LB_N;
    logic        Load_en;
    logic [9:0]  Load_addr;
    logic [15:0] Load_data;

    logic [15:0] drv;
    logic        drv_en;

    wire  [15:0] bus1;
    wire  [15:0] bus3;
    logic        dv1, dv3, re1, re3;

    int checks   = 0;
    int failures = 0;

    assign bus1 = drv_en ? drv : 16'hzzzz;
    assign bus3 = drv_en ? drv : 16'hzzzz;

    always #5 Clk = ~Clk;

    sram_responder #(.ADDR_BITS(10), .READ_LATENCY(1)) u1 (
        .Clk(Clk), .Reset(Reset), .A(A), .CE_N(CE_N), .OE_N(OE_N), .WE_N(WE_N),
        .UB_N(UB_N), .LB_N(LB_N), .Mem_bus(bus1), .Load_en(Load_en),
        .Load_addr(Load_addr), .Load_data(Load_data), .Data_valid(dv1), .Range_err(re1)
    );

    sram_responder #(.ADDR_BITS(10), .READ_LATENCY(3)) u3 (
        .Clk(Clk), .Reset(Reset), .A(A), .CE_N(CE_N), .OE_N(OE_N), .WE_N(WE_N),
        .UB_N(UB_N), .LB_N(LB_N), .Mem_bus(bus3), .Load_en(Load_en),
        .Load_addr(Load_addr), .Load_data(Load_data), .Data_valid(dv3), .Range_err(re3)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_bus();
        CE_N = 1'b1; OE_N = 1'b1; WE_N = 1'b1; UB_N = 1'b1; LB_N = 1'b1;
        drv_en = 1'b0; Load_en = 1'b0;
    endtask

    task automatic preload(input logic [9:0] a, input logic [15:0] d);
        Load_en = 1'b1; Load_addr = a; Load_data = d;
        tick();
        Load_en = 1'b0;
    endtask

    task automatic set_read(input logic [19:0] a);
        A = a; CE_N = 1'b0; OE_N = 1'b0; WE_N = 1'b1; UB_N = 1'b0; LB_N = 1'b0;
        drv_en = 1'b0;
    endtask

    task automatic bus_write(input logic [19:0] a, input logic [15:0] d, input logic ub_n, input logic lb_n);
        A = a; CE_N = 1'b0; OE_N = 1'b1; WE_N = 1'b0; UB_N = ub_n; LB_N = lb_n;
        drv = d; drv_en = 1'b1;
        tick();
        idle_bus();
    endtask

    initial begin
        Reset = 1'b0; A = '0; Load_addr = '0; Load_data = '0; drv = '0;
        idle_bus();

        // Reset state
        #1;
        chk("rst_dv1", {15'd0, dv1}, 16'd0);
        chk("rst_dv3", {15'd0, dv3}, 16'd0);
        chk("rst_re1", {15'd0, re1}, 16'd0);
        chk("rst_re3", {15'd0, re3}, 16'd0);
        tick(); tick();
        Reset = 1'b1;
        tick();

        // Preload program words
        preload(10'h000, 16'h5020);
        preload(10'h001, 16'h1234);
        preload(10'h002, 16'hFFFF);
        preload(10'h003, 16'h1111);

        // Latency-1 read of 0x00001
        set_read(20'h00001);
        tick();
        chk("l1_req_dv", {15'd0, dv1}, 16'd0);
        tick();
        chk("l1_dv", {15'd0, dv1}, 16'd1);
        chk("l1_data", bus1, 16'h1234);
        chk("l3_early_dv", {15'd0, dv3}, 16'd0);
        OE_N = 1'b1;
        #1;
        chk("l1_oe_release", {15'd0, dv1}, 16'd0);
        tick();
        chk("l1_idle_dv", {15'd0, dv1}, 16'd0);
        idle_bus();

        // Byte-masked writes over 0xFFFF
        bus_write(20'h00002, 16'hABCD, 1'b1, 1'b0);
        set_read(20'h00002);
        tick(); tick();
        chk("wr_lb_l1", bus1, 16'hFFCD);
        tick(); tick();
        chk("wr_lb_l3_dv", {15'd0, dv3}, 16'd1);
        chk("wr_lb_l3", bus3, 16'hFFCD);
        WE_N = 1'b0;
        #1;
        chk("we_abort_dv", {15'd0, dv1}, 16'd0);
        idle_bus();
        tick();
        bus_write(20'h00002, 16'h1200, 1'b0, 1'b1);
        set_read(20'h00002);
        tick(); tick();
        chk("wr_ub_l1", bus1, 16'h12CD);
        idle_bus();
        tick();

        // Latency-3 timing and address-change restart
        set_read(20'h00000);
        tick();
        chk("l3_e0", {15'd0, dv3}, 16'd0);
        tick();
        chk("l3_e1", {15'd0, dv3}, 16'd0);
        tick();
        chk("l3_e2", {15'd0, dv3}, 16'd0);
        tick();
        chk("l3_e3", {15'd0, dv3}, 16'd1);
        chk("l3_data0", bus3, 16'h5020);
        A = 20'h00001;
        tick();
        chk("l3_chg_drop", {15'd0, dv3}, 16'd0);
        chk("l1_chg_drop", {15'd0, dv1}, 16'd0);
        tick();
        chk("l1_chg_dv", {15'd0, dv1}, 16'd1);
        chk("l1_chg_data", bus1, 16'h1234);
        chk("l3_chg_e1", {15'd0, dv3}, 16'd0);
        tick();
        chk("l3_chg_e2", {15'd0, dv3}, 16'd0);
        tick();
        chk("l3_chg_dv", {15'd0, dv3}, 16'd1);
        chk("l3_chg_data", bus3, 16'h1234);
        idle_bus();
        tick();

        // Out-of-range read and write
        set_read(20'h00400);
        tick();
        chk("oor_rd_re1", {15'd0, re1}, 16'd1);
        chk("oor_rd_re3", {15'd0, re3}, 16'd1);
        chk("oor_rd_dv1", {15'd0, dv1}, 16'd0);
        tick();
        chk("oor_rd_dv1_hold", {15'd0, dv1}, 16'd0);
        idle_bus();
        tick();
        chk("oor_re_clear", {15'd0, re1}, 16'd0);
        bus_write(20'h00400, 16'hDEAD, 1'b0, 1'b0);
        chk("oor_wr_re1", {15'd0, re1}, 16'd1);
        set_read(20'h00000);
        tick(); tick();
        chk("oor_wr_word0", bus1, 16'h5020);
        idle_bus();
        tick();

        // Asynchronous reset in DRIVE
        set_read(20'h00001);
        tick(); tick();
        chk("pre_rst_dv", {15'd0, dv1}, 16'd1);
        #2;
        Reset = 1'b0;
        #1;
        chk("async_rst_dv", {15'd0, dv1}, 16'd0);
        tick();
        Reset = 1'b1;
        tick(); tick();
        chk("post_rst_dv", {15'd0, dv1}, 16'd1);
        chk("post_rst_data", bus1, 16'h1234);
        idle_bus();
        tick();

        // Preload blocked while CE_N=0, honoured with CE_N=1
        CE_N = 1'b0;
        preload(10'h003, 16'h7777);
        idle_bus();
        set_read(20'h00003);
        tick(); tick();
        chk("blocked_preload", bus1, 16'h1111);
        idle_bus();
        tick();
        preload(10'h003, 16'h7777);
        set_read(20'h00003);
        tick(); tick();
        chk("preload_ok", bus1, 16'h7777);
        idle_bus();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
